// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared definitions for the fixed-point calculator result path:
//            operation tag codes, serializer state encoding and the default
//            result widths used by the calculator and its consumers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  // Default result widths, shared with the upstream calculator.
  localparam int CALC_DATA_W = 8;
  localparam int CALC_PROD_W = 16;

  // Operation tags carried with each serialized word.
  localparam logic [1:0] TAG_SUM  = 2'd0;
  localparam logic [1:0] TAG_SUB  = 2'd1;
  localparam logic [1:0] TAG_PROD = 2'd2;
  localparam logic [1:0] TAG_DIV  = 2'd3;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage : calc_pkg

`default_nettype wire

// File: rtl/calc_sext.sv
// ============================================================================
// Module   : calc_sext
// Purpose  : Parameterised two's-complement sign extender, IN_W -> OUT_W.
//            OUT_W must be >= IN_W; equal widths pass straight through.
// Ports    : i_a [IN_W-1:0]  - signed input value
//            o_y [OUT_W-1:0] - sign-extended result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_a,
  output logic [OUT_W-1:0] o_y
);

  // A zero-width replication is illegal, so equal widths take a separate path.
  generate
    if (OUT_W > IN_W) begin : g_ext
      assign o_y = {{(OUT_W - IN_W){i_a[IN_W-1]}}, i_a};
    end else begin : g_pass
      assign o_y = i_a[OUT_W-1:0];
    end
  endgenerate

endmodule : calc_sext

`default_nettype wire

// File: rtl/calc_result_serializer.sv
// ============================================================================
// Module   : calc_result_serializer
// Purpose  : Captures one calculator result bundle (Sum, Sub, Prod, Div) per
//            valid/ready handshake and streams it out as four tagged OUT_W
//            words under downstream backpressure. A new bundle may be taken
//            in the same cycle the DIV word is accepted, so frames can run
//            back to back with no bubble.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready, sum, sub, prod, div      - input bundle
//            out_valid/out_ready, out_data, out_tag,
//            out_last                                    - output word stream
//            frame_cnt                                   - frames done mod 256
//            busy                                        - frame in progress
//            out_parity (only with CALC_SER_PARITY_EN)   - XOR of {tag,data}
// Options  : `define CALC_SER_PARITY_EN to add the out_parity output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_result_serializer
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int PROD_W = CALC_PROD_W,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sum,
  input  logic [DATA_W-1:0] sub,
  input  logic [PROD_W-1:0] prod,
  input  logic [DATA_W-1:0] div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_tag,
  output logic              out_last,
  output logic [7:0]        frame_cnt,
`ifdef CALC_SER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;

  // Sum is not kept: it goes straight into the first output word at capture.
  logic [DATA_W-1:0]   r_sub;
  logic [PROD_W-1:0]   r_prod;
  logic [DATA_W-1:0]   r_div;

  logic [OUT_W-1:0]    r_out_data;
  logic [1:0]          r_out_tag;
  logic [7:0]          r_frame_cnt;

  logic [OUT_W-1:0]    w_sum_x;
  logic [OUT_W-1:0]    w_sub_x;
  logic [OUT_W-1:0]    w_prod_x;
  logic [OUT_W-1:0]    w_div_x;

  logic                w_beat;
  logic                w_div_done;
  logic                w_capture;
  logic                w_load;
  logic [OUT_W-1:0]    w_data_nxt;
  logic [1:0]          w_tag_nxt;

  // --------------------------------------------------------------------------
  // Sign extenders
  // --------------------------------------------------------------------------
  calc_sext #(.IN_W(DATA_W), .OUT_W(OUT_W)) u_sext_sum (
    .i_a (sum),
    .o_y (w_sum_x)
  );

  calc_sext #(.IN_W(DATA_W), .OUT_W(OUT_W)) u_sext_sub (
    .i_a (r_sub),
    .o_y (w_sub_x)
  );

  calc_sext #(.IN_W(PROD_W), .OUT_W(OUT_W)) u_sext_prod (
    .i_a (r_prod),
    .o_y (w_prod_x)
  );

  calc_sext #(.IN_W(DATA_W), .OUT_W(OUT_W)) u_sext_div (
    .i_a (r_div),
    .o_y (w_div_x)
  );

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign w_beat     = (r_state == EMIT) && out_ready;
  assign w_div_done = w_beat && (r_out_tag == TAG_DIV);
  assign w_capture  = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        // Stay in EMIT when a new bundle is taken alongside the DIV beat.
        if (w_div_done && !in_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = (r_state == EMIT);
    busy      = (r_state == EMIT);
    // Ready reopens combinationally in the DIV handshake cycle.
    in_ready  = (r_state == IDLE) || w_div_done;
    // Tag stays at DIV after the frame drains, so qualify with valid.
    out_last  = (r_state == EMIT) && (r_out_tag == TAG_DIV);
  end

  // --------------------------------------------------------------------------
  // Next output word selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_load     = 1'b0;
    w_data_nxt = r_out_data;
    w_tag_nxt  = r_out_tag;
    if (w_capture) begin
      w_load     = 1'b1;
      w_data_nxt = w_sum_x;
      w_tag_nxt  = TAG_SUM;
    end else if (w_beat && (r_out_tag != TAG_DIV)) begin
      w_load = 1'b1;
      case (r_out_tag)
        TAG_SUM: begin
          w_data_nxt = w_sub_x;
          w_tag_nxt  = TAG_SUB;
        end
        TAG_SUB: begin
          w_data_nxt = w_prod_x;
          w_tag_nxt  = TAG_PROD;
        end
        default: begin
          w_data_nxt = w_div_x;
          w_tag_nxt  = TAG_DIV;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Capture and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sub      <= '0;
      r_prod     <= '0;
      r_div      <= '0;
      r_out_data <= '0;
      r_out_tag  <= TAG_SUM;
    end else begin
      if (w_capture) begin
        r_sub  <= sub;
        r_prod <= prod;
        r_div  <= div;
      end
      if (w_load) begin
        r_out_data <= w_data_nxt;
        r_out_tag  <= w_tag_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= 8'd0;
    end else if (w_div_done) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign frame_cnt = r_frame_cnt;

`ifdef CALC_SER_PARITY_EN
  logic r_parity;

  // Computed from the word about to be loaded so it updates with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^{w_tag_nxt, w_data_nxt};
    end
  end

  assign out_parity = r_parity;
`endif

endmodule : calc_result_serializer

`default_nettype wire

// File: tb/tb_calc_result_serializer.sv
// ============================================================================
// Module   : tb_calc_result_serializer
// Purpose  : Self-checking bench for calc_result_serializer: table vectors,
//            hand-written backpressure / back-to-back / reset sequences and a
//            randomized run against a queue-based reference model.
// Options  : honours CALC_SER_PARITY_EN (checks out_parity when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_result_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  sum;
  logic [7:0]  sub;
  logic [15:0] prod;
  logic [7:0]  div;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;
  logic [7:0]  frame_cnt;
  logic        busy;
`ifdef CALC_SER_PARITY_EN
  logic        out_parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  calc_result_serializer #(
    .DATA_W (8),
    .PROD_W (16),
    .OUT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sub       (sub),
    .prod      (prod),
    .div       (div),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
`ifdef CALC_SER_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  tag;
    logic        last;
  } word_t;

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  sb;
    logic [15:0] p;
    logic [7:0]  dv;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
  } vec_t;

  word_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sx8(input logic [7:0] v);
    int t;
    t = $signed(v);
    return t[15:0];
  endfunction

  task automatic check_word(input string nm, input logic [15:0] d, input logic [1:0] t);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"},  32'(out_data),  32'(d));
    chk({nm, "_tag"},   32'(out_tag),   32'(t));
    chk({nm, "_last"},  32'(out_last),  32'(t == 2'd3));
`ifdef CALC_SER_PARITY_EN
    chk({nm, "_parity"}, 32'(out_parity), 32'(^{t, d}));
`endif
  endtask

  task automatic apply_bundle(input logic [7:0] s, input logic [7:0] sb,
                              input logic [15:0] p, input logic [7:0] dv);
    sum  = s;
    sub  = sb;
    prod = p;
    div  = dv;
  endtask

  // Bounded watchdog so the bench can never hang.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    vec_t tbl[3];
    logic [15:0] ew[4];
    int model_cnt;
    int cyc;
    logic cap;
    logic exp_ir;
    word_t w;

    tbl[0] = '{8'd15, 8'd5, 16'd50, 8'd2,
               16'h000F, 16'h0005, 16'h0032, 16'h0002};
    tbl[1] = '{8'd4, 8'hF6, 16'hFFEB, 8'h00,
               16'h0004, 16'hFFF6, 16'hFFEB, 16'h0000};
    tbl[2] = '{8'h81, 8'h7F, 16'hFF80, 8'h80,
               16'hFF81, 16'h007F, 16'hFF80, 16'hFF80};

    // ---------------- reset ----------------
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply_bundle(8'h00, 8'h00, 16'h0000, 8'h00);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef CALC_SER_PARITY_EN
    chk("rst_parity",    32'(out_parity), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 3; i++) begin
      apply_bundle(tbl[i].s, tbl[i].sb, tbl[i].p, tbl[i].dv);
      in_valid = 1'b1;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ew[0] = tbl[i].e0; ew[1] = tbl[i].e1; ew[2] = tbl[i].e2; ew[3] = tbl[i].e3;
      for (int k = 0; k < 4; k++) begin
        check_word("tbl", ew[k], 2'(k));
        chk("tbl_busy", 32'(busy), 32'd1);
        tick();
      end
      chk("tbl_end_valid", 32'(out_valid), 32'd0);
      chk("tbl_end_busy",  32'(busy),      32'd0);
      chk("tbl_frame_cnt", 32'(frame_cnt), 32'(i + 1));
    end

    // ---------------- backpressure on PROD (A=15, B=-4) ----------------
    apply_bundle(8'd11, 8'd19, 16'hFFC4, 8'hFD);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_word("bp_sum", 16'h000B, 2'd0);
    tick();
    check_word("bp_sub", 16'h0013, 2'd1);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_word("bp_hold", 16'hFFC4, 2'd2);
      tick();
    end
    check_word("bp_hold_end", 16'hFFC4, 2'd2);
    out_ready = 1'b1;
    tick();
    check_word("bp_div", 16'hFFFD, 2'd3);
    tick();
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd4);

    // ---------------- back-to-back (A=10,B=5 then A=-8,B=-6) ----------------
    apply_bundle(tbl[0].s, tbl[0].sb, tbl[0].p, tbl[0].dv);
    in_valid = 1'b1;
    tick();
    apply_bundle(8'hF2, 8'hFE, 16'h0030, 8'h01);
    out_ready = 1'b1;
    ew[0] = tbl[0].e0; ew[1] = tbl[0].e1; ew[2] = tbl[0].e2; ew[3] = tbl[0].e3;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_word("b2b_f1", ew[k], 2'(k));
      chk("b2b_in_ready", 32'(in_ready), 32'(k == 3));
      tick();
    end
    in_valid = 1'b0;
    check_word("b2b_f2_sum", 16'hFFF2, 2'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_frame_cnt1", 32'(frame_cnt), 32'd5);
    tick();
    check_word("b2b_f2_sub", 16'hFFFE, 2'd1);
    tick();
    check_word("b2b_f2_prod", 16'h0030, 2'd2);
    tick();
    check_word("b2b_f2_div", 16'h0001, 2'd3);
    tick();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);
    chk("b2b_frame_cnt2", 32'(frame_cnt), 32'd6);

    // ---------------- reset mid-frame with tag-1 word pending ----------------
    apply_bundle(tbl[1].s, tbl[1].sb, tbl[1].p, tbl[1].dv);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_word("mr_sub", 16'hFFF6, 2'd1);
    out_ready = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data",  32'(out_data),  32'd0);
    chk("mr_out_tag",   32'(out_tag),   32'd0);
    chk("mr_out_last",  32'(out_last),  32'd0);
    chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mr_busy",      32'(busy),      32'd0);
    tick();
    #1;
    rst = 1'b1;
    tick();
    chk("mr_post_in_ready",  32'(in_ready),  32'd1);
    chk("mr_post_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mr_post_valid",     32'(out_valid), 32'd0);

    // ---------------- randomized run against queue model ----------------
    model_cnt = 0;
    cyc       = 0;
    q.delete();
    while (model_cnt < 300 && cyc < 20000) begin
      cyc++;
      if (!in_valid && ($urandom_range(0, 99) < 60)) begin
        int a, b, r_s, r_d, r_p, r_dv;
        a = $signed(8'($urandom_range(0, 255)));
        b = $signed(8'($urandom_range(0, 255)));
        if (b == 0) b = 1;
        r_s  = a + b;
        r_d  = a - b;
        r_p  = a * b;
        r_dv = a / b;
        apply_bundle(r_s[7:0], r_d[7:0], r_p[15:0], r_dv[7:0]);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 99) < 75);
      #1;
      exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("rnd_in_ready",  32'(in_ready),  32'(exp_ir));
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_busy",      32'(busy),      32'(q.size() != 0));
      chk("rnd_frame_cnt", 32'(frame_cnt), 32'(model_cnt % 256));
      if (q.size() != 0) begin
        check_word("rnd", q[0].data, q[0].tag);
      end
      if (q.size() != 0 && out_ready) begin
        w = q.pop_front();
        if (w.last) model_cnt++;
      end
      cap = in_valid && exp_ir;
      if (cap) begin
        q.push_back('{sx8(sum), 2'd0, 1'b0});
        q.push_back('{sx8(sub), 2'd1, 1'b0});
        q.push_back('{prod,     2'd2, 1'b0});
        q.push_back('{sx8(div), 2'd3, 1'b1});
      end
      tick();
      if (cap) in_valid = 1'b0;
    end
    chk("rnd_frames_completed", 32'(model_cnt >= 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_calc_result_serializer

`default_nettype wire

// File: doc/calc_result_serializer.md
Name: calc_result_serializer

Overview:
- Downstream consumer of the fixed-point calculator's result bundle (Sum, Sub, Prod, Div).
- Captures one result set per valid/ready handshake and streams it out as four 16-bit words, one per accepted output beat, each tagged with its operation code.
- Feeds the display/UART/log path, which accepts one word at a time under backpressure.

Parameters:
- DATA_W, 8: width of the signed Sum/Sub/Div results.
- PROD_W, 16: width of the signed Prod result.
- OUT_W, 16: output word width; must be >= PROD_W. 8-bit results are sign-extended to this width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  result bundle valid.
- in_ready  out  1  block can accept a bundle.
- sum  in  DATA_W  signed A+B.
- sub  in  DATA_W  signed A-B.
- prod  in  PROD_W  signed A*B.
- div  in  DATA_W  signed A/B.
- out_valid  out  1  out_data/out_tag valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  sign-extended result word.
- out_tag  out  2  0=SUM, 1=SUB, 2=PROD, 3=DIV.
- out_last  out  1  high with the DIV word, marking end of frame.
- frame_cnt  out  8  completed frames, modulo 256.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst low, async): state IDLE. out_valid=0, out_data=0, out_tag=0, out_last=0, frame_cnt=0, busy=0. Capture registers are cleared.
- States:
  - IDLE: in_ready=1.
  - EMIT: in_ready=0, except in the cycle where the DIV word handshakes (out_valid & out_ready & out_tag==3). In that cycle in_ready=1, combinationally from out_ready.
- Input capture:
  - Occurs on in_valid & in_ready.
  - Registers all four results.
  - Next cycle: out_valid=1, out_tag=0, out_data=sext(sum). Latency is 1 clock from capture to the first word.
- Per output beat:
  - A beat is accepted on out_valid & out_ready.
  - Tag advances 0→1→2→3; out_data updates on the next edge to sext(sub), then prod (sign-extended if PROD_W<OUT_W), then sext(div).
  - out_last=1 only when out_tag==3.
- Backpressure: while out_valid & !out_ready, out_data, out_tag and out_last hold stable. No word is ever skipped or duplicated.
- End of frame (DIV beat accepted):
  - frame_cnt increments, wrapping 255→0.
  - If in_valid is also high that same cycle, the new bundle is captured and the next cycle presents its SUM word. Back-to-back frames have zero bubble.
  - Otherwise: return to IDLE, out_valid=0, busy=0.
- busy=1 from the cycle after capture until the DIV beat is accepted.
- Input bundle values are ignored when not captured. The upstream stage holds values while in_ready=0.
- Reset mid-frame: partial frame discarded, no out_last issued, frame_cnt returns to 0.
- Arithmetic: no modification of values; pure sign extension. Division semantics (truncation toward zero) belong to the upstream stage.

Optional Feature:
- Macro: CALC_SER_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = even parity (XOR-reduce) over {out_tag, out_data}. It is registered together with out_data and held under backpressure, and is 0 at reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package calc_pkg:
  - Op-tag constants TAG_SUM=0, TAG_SUB=1, TAG_PROD=2, TAG_DIV=3.
  - State enum {IDLE, EMIT}.
  - DATA_W/PROD_W defaults, shared with the calculator.
- One natural sub-module: calc_sext, a parameterised sign-extender from IN_W to OUT_W, instantiated per 8-bit result.
- FSM and capture registers stay in the top module.

Test Plan:
- A=10, B=5 bundle (sum=15, sub=5, prod=50, div=2), out_ready=1 → words 0x000F/0x0005/0x0032/0x0002 with tags 0..3, out_last on the 4th word, frame_cnt=1.
- A=-3, B=7 (sum=4, sub=-10, prod=-21, div=0) → 0x0004, 0xFFF6, 0xFFEB, 0x0000. Checks sign extension.
- Backpressure: out_ready low for 3 cycles during the PROD word (A=15, B=-4, prod=-60) → out_data holds 0xFFC4 and tag 2 stable throughout. Next word appears only after out_ready rises.
- Back-to-back: second bundle (A=-8, B=-6) held at in_valid during the first frame → in_ready pulses only in the DIV-handshake cycle. SUM of the second frame (0xFFF2) appears the very next cycle with no bubble.
- Reset asserted while the tag-1 word is pending → all outputs return to reset values immediately (asynchronously). After release, in_ready=1 and frame_cnt=0.
- 256 consecutive frames → frame_cnt wraps 255→0. With CALC_SER_PARITY_EN defined, out_parity matches XOR-reduce of {tag,data} on every beat.
